// File: rtl/atmega_io_arbiter.sv
// Round-robin arbiter sharing one ATmega-style I/O register bus between NUM_REQ requesters.
// Optional requester lock for atomic read-modify-write: define ATMEGA_IO_ARB_LOCK_EN.
module atmega_io_arbiter #(
    parameter int unsigned BUS_ADDR_DATA_LEN = 8,
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned NUM_REQ           = 4
) (
    input  logic                                 rst,
    input  logic                                 clk,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0]                   lock,
    input  logic [NUM_REQ*BUS_ADDR_DATA_LEN-1:0] req_addr,
    input  logic [NUM_REQ-1:0]                   req_wr,
    input  logic [NUM_REQ-1:0]                   req_rd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wdat,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [NUM_REQ-1:0]                   ack,
    output logic [DATA_WIDTH-1:0]                rdat,
    output logic [BUS_ADDR_DATA_LEN-1:0]         addr_dat,
    output logic                                 wr_dat,
    output logic                                 rd_dat,
    output logic [DATA_WIDTH-1:0]                bus_dat_out,
    input  logic [DATA_WIDTH-1:0]                bus_dat_in
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [IDX_W-1:0]             winner;
    logic [IDX_W-1:0]             last_winner;
    logic [IDX_W-1:0]             pick;
    logic                         found;
    logic                         load;
    logic [NUM_REQ-1:0]           win_oh;
    logic [NUM_REQ-1:0]           cand_mask;
    int unsigned                  cand;
    logic [BUS_ADDR_DATA_LEN-1:0] cmd_addr;
    logic                         cmd_wr;
    logic                         cmd_rd;
    logic [DATA_WIDTH-1:0]        cmd_wdat;
    logic                         in_access;

`ifndef ATMEGA_IO_ARB_LOCK_EN
    logic lock_unused;
    assign lock_unused = ^lock;
`endif

    always_comb begin
        win_oh         = '0;
        win_oh[winner] = 1'b1;
    end

    // Search begins just after the last winner, so the last winner is the lowest priority.
    always_comb begin
        cand_mask = req;
        if (state == ACK) begin
            cand_mask = req & ~win_oh;
        end
        found = 1'b0;
        pick  = winner;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_winner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && cand_mask[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
`ifdef ATMEGA_IO_ARB_LOCK_EN
        if ((state == ACK) && lock[winner] && req[winner]) begin
            found = 1'b1;
            pick  = winner;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = ACK;
            ACK: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            winner      <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            cmd_addr    <= '0;
            cmd_wr      <= 1'b0;
            cmd_rd      <= 1'b0;
            cmd_wdat    <= '0;
            rdat        <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                winner   <= pick;
                cmd_addr <= req_addr[32'(pick) * BUS_ADDR_DATA_LEN +: BUS_ADDR_DATA_LEN];
                cmd_wr   <= req_wr[pick];
                // A command with both strobes set is treated as a write only.
                cmd_rd   <= req_rd[pick] & ~req_wr[pick];
                cmd_wdat <= req_wdat[32'(pick) * DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == ACCESS) begin
                last_winner <= winner;
                if (cmd_rd) begin
                    rdat <= bus_dat_in;
                end
            end
        end
    end

    // Grant, ack and bus drive are decoded from registered state so reset clears them at once.
    assign in_access   = (state == ACCESS);
    assign gnt         = in_access ? win_oh : '0;
    assign ack         = (state == ACK) ? win_oh : '0;
    assign addr_dat    = in_access ? cmd_addr : '0;
    assign wr_dat      = in_access & cmd_wr;
    assign rd_dat      = in_access & cmd_rd;
    assign bus_dat_out = in_access ? cmd_wdat : '0;

endmodule

// File: tb/tb_atmega_io_arbiter.sv
// Scoreboard bench for atmega_io_arbiter: a transaction-level model predicts each bus cycle,
// a negedge monitor compares the DUT against the predictions.
module tb_atmega_io_arbiter;

    localparam int unsigned N  = 4;
    localparam int          NI = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req, lock, req_wr, req_rd, gnt, ack;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdat;
    logic [DW-1:0]   rdat, bus_dat_out, bus_dat_in;
    logic [AW-1:0]   addr_dat;
    logic            wr_dat, rd_dat;

    logic          r_req [N];
    logic          r_lock[N];
    logic          r_wr  [N];
    logic          r_rd  [N];
    logic [AW-1:0] r_addr[N];
    logic [DW-1:0] r_wdat[N];

    typedef struct {
        int            acc_cyc;
        int            who;
        logic [AW-1:0] addr;
        logic          wr;
        logic          rd;
        logic [DW-1:0] wdat;
    } txn_t;

    txn_t          exp_q[$];
    int            glog_who[$];
    int            glog_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int unsigned   issue_seq[N];
    int unsigned   granted_seq[N];
    int            gcyc[N];
    int            last_served = NI - 1;
    int            last_grant_cyc = -100;
    logic [DW-1:0] model_rdat = '0;

    atmega_io_arbiter #(.BUS_ADDR_DATA_LEN(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .rst(rst), .clk(clk), .req(req), .lock(lock), .req_addr(req_addr),
        .req_wr(req_wr), .req_rd(req_rd), .req_wdat(req_wdat), .gnt(gnt), .ack(ack),
        .rdat(rdat), .addr_dat(addr_dat), .wr_dat(wr_dat), .rd_dat(rd_dat),
        .bus_dat_out(bus_dat_out), .bus_dat_in(bus_dat_in)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] periph(input logic [AW-1:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    always_comb begin
        req = '0; lock = '0; req_wr = '0; req_rd = '0; req_addr = '0; req_wdat = '0;
        for (int i = 0; i < NI; i++) begin
            req[i]               = r_req[i];
            lock[i]              = r_lock[i];
            req_wr[i]            = r_wr[i];
            req_rd[i]            = r_rd[i];
            req_addr[i*AW +: AW] = r_addr[i];
            req_wdat[i*DW +: DW] = r_wdat[i];
        end
    end

    always_comb bus_dat_in = periph(addr_dat);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: at every edge not closing a bus cycle, the first pending requester after the
    // last one served (cyclically) wins; the one just acked is skipped unless it holds the lock.
    always @(posedge clk) begin : model
        int   win;
        bit   ack_edge;
        txn_t t;
        cyc      = cyc + 1;
        win      = -1;
        ack_edge = (last_grant_cyc == cyc - 2);
        if (rst) begin
            exp_q.delete();
            last_served    = NI - 1;
            last_grant_cyc = -100;
            for (int i = 0; i < NI; i++) granted_seq[i] = '1;
        end else if (last_grant_cyc != cyc - 1) begin
`ifdef ATMEGA_IO_ARB_LOCK_EN
            if (ack_edge && r_lock[last_served] && r_req[last_served]) win = last_served;
`endif
            for (int k = 1; k <= NI; k++) begin
                int c;
                c = (last_served + k) % NI;
                if (win < 0 && r_req[c] && granted_seq[c] != issue_seq[c] &&
                    !(ack_edge && c == last_served)) win = c;
            end
            if (win >= 0) begin
                t.acc_cyc = cyc;
                t.who     = win;
                t.addr    = r_addr[win];
                t.wr      = r_wr[win];
                t.rd      = r_rd[win] & ~r_wr[win];
                t.wdat    = r_wdat[win];
                exp_q.push_back(t);
                granted_seq[win] = issue_seq[win];
                gcyc[win]        = cyc;
                last_served      = win;
                last_grant_cyc   = cyc;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        logic [17:0]  eb;
        if (rst) begin
            model_rdat = '0;
        end else begin
            eg = '0; ea = '0; eb = '0;
            if (exp_q.size() > 0) begin
                if (exp_q[0].acc_cyc == cyc) begin
                    eg[exp_q[0].who] = 1'b1;
                    eb = {exp_q[0].addr, exp_q[0].wr, exp_q[0].rd, exp_q[0].wdat};
                end else if (exp_q[0].acc_cyc + 1 == cyc) begin
                    ea[exp_q[0].who] = 1'b1;
                    if (exp_q[0].rd) model_rdat = periph(exp_q[0].addr);
                    void'(exp_q.pop_front());
                end
            end
            check("gnt", 64'(gnt), 64'(eg));
            check("bus", 64'({addr_dat, wr_dat, rd_dat, bus_dat_out}), 64'(eb));
            check("ack", 64'(ack), 64'(ea));
            check("rdat", 64'(rdat), 64'(model_rdat));
            for (int i = 0; i < NI; i++) begin
                if (gnt[i]) begin
                    glog_who.push_back(i);
                    glog_cyc.push_back(cyc);
                end
            end
        end
    end

    function automatic bit granted(input int i);
        return granted_seq[i] == issue_seq[i];
    endfunction

    function automatic bit done(input int i);
        return r_req[i] && granted(i) && (cyc >= gcyc[i] + 2);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a, input logic w, input logic r,
                         input logic [DW-1:0] d, input logic lk);
        r_addr[i] = a; r_wr[i] = w; r_rd[i] = r; r_wdat[i] = d; r_lock[i] = lk;
        r_req[i]  = 1'b1;
        issue_seq[i]++;
    endtask

    task automatic issue_rand(input int i);
        issue(i, AW'($urandom), 1'($urandom), 1'($urandom), DW'($urandom),
              ($urandom_range(0, 7) == 0));
    endtask

    task automatic wait_done(input int i, input string name);
        int n;
        n = 0;
        while (!done(i) && n < 40) begin
            step();
            n++;
        end
        check(name, 64'(done(i)), 64'd1);
        r_req[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : driver
        int ph;
        int n;
        int ord[3];
        for (int i = 0; i < NI; i++) begin
            r_req[i] = 0; r_lock[i] = 0; r_wr[i] = 0; r_rd[i] = 0; r_addr[i] = '0; r_wdat[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({gnt, ack, rdat, addr_dat, wr_dat, rd_dat, bus_dat_out}), 64'd0);
        @(negedge clk); #1;
        rst = 1'b0;

        // single write, then single read
        step();
        issue(2, 8'h20, 1'b1, 1'b0, 8'hA5, 1'b0);
        wait_done(2, "write_done");
        step();
        issue(1, 8'h24, 1'b0, 1'b1, 8'h00, 1'b0);
        wait_done(1, "read_done");
        step();
        issue(3, 8'h30, 1'b1, 1'b1, 8'h5A, 1'b0);
        wait_done(3, "wr_and_rd_done");
        step();
        issue(0, 8'h31, 1'b0, 1'b0, 8'hFF, 1'b0);
        wait_done(0, "null_done");

        // fairness from reset with all requesters saturated
        pulse_reset();
        glog_who.delete(); glog_cyc.delete();
        for (int i = 0; i < NI; i++) issue_rand(i);
        for (int i = 0; i < NI; i++) r_lock[i] = 1'b0;
        n = 0;
        while (glog_who.size() < 5 && n < 60) begin
            step();
            for (int i = 0; i < NI; i++) if (done(i)) issue(i, AW'($urandom), 1'b1, 1'b0, DW'($urandom), 1'b0);
            n++;
        end
        check("fair_count", 64'(glog_who.size() >= 5), 64'd1);
        if (glog_who.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("fair_order", 64'(glog_who[k]), 64'(k % NI));
            for (int k = 0; k < 4; k++) check("fair_spacing", 64'(glog_cyc[k+1] - glog_cyc[k]), 64'd2);
        end
        for (int i = 0; i < NI; i++) r_req[i] = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin step(); n++; end
        repeat (2) step();

        // withdrawn request: req[1] pulses while requester 0 is on the bus
        glog_who.delete(); glog_cyc.delete();
        issue(0, 8'h40, 1'b1, 1'b0, 8'h11, 1'b0);
        n = 0;
        while (!granted(0) && n < 20) begin step(); n++; end
        issue(1, 8'h41, 1'b1, 1'b0, 8'h22, 1'b0);
        step();
        r_req[1] = 1'b0;
        wait_done(0, "withdraw_done");
        repeat (3) step();
        n = 0;
        foreach (glog_who[k]) if (glog_who[k] == 1) n++;
        check("withdraw_gnt1", 64'(n), 64'd0);

        // lock: requester 1 reads 0x20 then writes 0x21 while requester 0 waits
        glog_who.delete(); glog_cyc.delete();
        issue(0, 8'h50, 1'b1, 1'b0, 8'h33, 1'b0);
        issue(1, 8'h20, 1'b0, 1'b1, 8'h00, 1'b1);
        ph = 0; n = 0;
        while ((ph != 3 || r_req[0]) && n < 40) begin
            step();
            if (done(0)) r_req[0] = 1'b0;
            case (ph)
                0: if (granted(1) && cyc == gcyc[1] + 1) begin
                       issue(1, 8'h21, 1'b1, 1'b0, 8'h77, 1'b1);
                       ph = 1;
                   end
                1: if (granted(1) && cyc == gcyc[1] + 1) begin
                       r_lock[1] = 1'b0;
                       ph = 2;
                   end
                2: if (done(1)) begin r_req[1] = 1'b0; ph = 3; end
                default: ;
            endcase
            n++;
        end
`ifdef ATMEGA_IO_ARB_LOCK_EN
        ord = '{1, 1, 0};
`else
        ord = '{1, 0, 1};
`endif
        check("lock_count", 64'(glog_who.size()), 64'd3);
        if (glog_who.size() == 3)
            for (int k = 0; k < 3; k++) check("lock_order", 64'(glog_who[k]), 64'(ord[k]));
        repeat (2) step();

        // reset in the middle of a write by requester 3
        issue(3, 8'h60, 1'b1, 1'b0, 8'hC3, 1'b0);
        n = 0;
        while (!granted(3) && n < 20) begin step(); n++; end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset_outputs", 64'({gnt, ack, rdat, addr_dat, wr_dat, rd_dat, bus_dat_out}), 64'd0);
        issue(0, 8'h61, 1'b0, 1'b1, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        glog_who.delete(); glog_cyc.delete();
        n = 0;
        while ((r_req[0] || r_req[3]) && n < 40) begin
            step();
            if (done(0)) r_req[0] = 1'b0;
            if (done(3)) r_req[3] = 1'b0;
            n++;
        end
        check("midreset_grants", 64'(glog_who.size()), 64'd2);
        if (glog_who.size() >= 1) check("midreset_first", 64'(glog_who[0]), 64'd0);

        // randomized traffic with occasional withdrawals and locks
        for (int c = 0; c < 2500; c++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                if (r_lock[i] && $urandom_range(0, 3) == 0) r_lock[i] = 1'b0;
                if (r_req[i]) begin
                    if (done(i)) begin
                        if ($urandom_range(0, 1) == 0) issue_rand(i);
                        else r_req[i] = 1'b0;
                    end else if (!granted(i) && $urandom_range(0, 15) == 0) begin
                        r_req[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    issue_rand(i);
                end
            end
        end
        for (int i = 0; i < NI; i++) begin r_req[i] = 1'b0; r_lock[i] = 1'b0; end
        repeat (10) step();
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atmega_io_arbiter.md
# atmega_io_arbiter

Round-robin arbiter that shares the single ATmega-style I/O register bus between several requesters, for example the CPU core, a DMA engine and a debug port. The bus carries one address, write strobe, read strobe and data. The block sits between the requesters and the I/O peripherals (PIO ports, timers, UART). It registers the winning command, drives it onto the bus for exactly one cycle, captures read data, and returns a one-cycle acknowledge. An optional lock lets one requester perform atomic read-modify-write sequences.

## Interface

Parameters:
- BUS_ADDR_DATA_LEN, 8, I/O address width.
- DATA_WIDTH, 8, I/O data width.
- NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
- rst  in  1  asynchronous reset, active-high.
- clk  in  1  single clock; all state is on the rising edge.
- req  in  NUM_REQ  per-requester transaction request.
- lock  in  NUM_REQ  per-requester bus lock; ignored unless the lock feature is compiled in.
- req_addr  in  NUM_REQ*BUS_ADDR_DATA_LEN  flattened addresses; requester i occupies slice [i*BUS_ADDR_DATA_LEN +: BUS_ADDR_DATA_LEN].
- req_wr  in  NUM_REQ  write command.
- req_rd  in  NUM_REQ  read command.
- req_wdat  in  NUM_REQ*DATA_WIDTH  flattened write data.
- gnt  out  NUM_REQ  one-hot; high during the granted requester's bus cycle.
- ack  out  NUM_REQ  one-hot, one-cycle transaction-complete pulse.
- rdat  out  DATA_WIDTH  registered read data; valid while ack is high and held until the next read completes.
- addr_dat  out  BUS_ADDR_DATA_LEN  I/O bus address.
- wr_dat  out  1  I/O bus write strobe.
- rd_dat  out  1  I/O bus read strobe.
- bus_dat_out  out  DATA_WIDTH  write data driven to the peripherals.
- bus_dat_in  in  DATA_WIDTH  combinational read data returned from the peripherals.

## Operation

- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any req bit is set, pick the winner by round-robin. The search starts at last_winner+1 and wraps at NUM_REQ-1 → 0. On the winning edge:
  - register the winner's addr, wr, rd and wdat;
  - set gnt[winner];
  - go to ACCESS.
- With no request, the FSM stays in IDLE.
- ACCESS (exactly one cycle): drive the registered command onto addr_dat, wr_dat/rd_dat and bus_dat_out.
  - If rd, capture bus_dat_in into rdat at the closing edge.
  - Update last_winner.
  - Go to ACK.
- ACK: ack[winner]=1 and gnt=0. Arbitration runs in this same cycle.
  - The just-served requester is masked, since its req may still be high.
  - If another request is pending, the winner is registered and the FSM goes straight to ACCESS; otherwise it returns to IDLE.
- Requester handshake rules:
  - hold the command stable while req is high and gnt has not yet asserted;
  - deassert req, or present a new command, in the cycle after ack.
- A req dropped before it is granted is withdrawn: no bus cycle occurs and no ack is issued.
- A req dropped after grant has no effect; the registered transaction completes and is acked.
- wr and rd both set: the transaction is a write only, and rd_dat stays 0.
- Neither wr nor rd set: null transaction. The bus cycle runs with both strobes 0, ack is still issued, and rdat is unchanged.
- Bus outputs are 0 in IDLE and ACK. wr_dat and rd_dat are never high in the same cycle.

## Timing

- Reset values: gnt=0, ack=0, rdat=0, addr_dat=0, wr_dat=0, rd_dat=0, bus_dat_out=0, state=IDLE, last_winner=NUM_REQ-1 (requester 0 wins first).
- Reset applies immediately, with no clock edge needed. A transaction aborted by reset is never acked.
- Latency, request sampled at edge 0: ACCESS and gnt during cycle 0→1; ack and rdat valid during cycle 1→2.
- Back-to-back service of different requesters: one bus cycle every 2 clocks.
- Worst-case wait for an unlocked requester: (NUM_REQ-1) transactions.

## Configuration

- ATMEGA_IO_ARB_LOCK_EN defined:
  - If lock[winner] is high in the ACK cycle and req[winner] is high, the same requester is regranted; the served-requester mask and round-robin are bypassed.
  - The lock is held for as long as lock[winner] stays high, giving atomic read-modify-write.
  - Lock inputs from requesters that are not being served are ignored.
- ATMEGA_IO_ARB_LOCK_EN undefined: the lock port exists but is ignored, and strict round-robin always applies.

## Test plan

- Single write, NUM_REQ=4: req[2] with addr 0x20, wdat 0xA5 → next cycle gnt=4'b0100, addr_dat=0x20, wr_dat=1, bus_dat_out=0xA5; following cycle ack=4'b0100.
- Read: req[1] with rd, addr 0x24, bus_dat_in=0x3C during ACCESS → rdat=0x3C with ack[1]; rd_dat high for exactly 1 cycle.
- Fairness: req=4'b1111 held after reset → grants in order 0,1,2,3,0, one ACCESS every 2 clocks.
- Lock (macro defined): requester 1 holds lock across a read of 0x20 then a write of 0x21 while req[0] is pending → both requester-1 cycles run consecutively, then requester 0 is served. With the macro undefined, requester 0 is served between them.
- Reset mid-ACCESS: assert rst during a write to requester 3 → all outputs 0 immediately, no ack[3]; after release, req[3] and req[0] pending → requester 0 is granted first.
- Withdrawn request: req[1] pulses for 1 cycle while requester 0 is in ACCESS → no gnt[1] and no ack[1].
